// File: rtl/alu_mc.sv
// Multi-cycle ALU. Single-cycle logic/arithmetic ops take one cycle.
// Unsigned multiply uses shift-add and unsigned divide uses a restoring
// algorithm; each runs WIDTH iterations.
// Both iterative ops share one 2*WIDTH accumulator laid out as {hi, lo}:
//   multiply : {partial product high, multiplier bits still to consume}
//   divide   : {partial remainder, dividend bits shifting into quotient}
// Because both layouts finish as {hi, y}, one write path serves both ops.
//
// state  | meaning
// IDLE   | waiting for start; start is accepted only here
// RUN    | one multiply/divide iteration per cycle; busy=1
// DONE   | results valid for this cycle only; done=1
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_MULU = 3'b011;
   localparam logic [2:0] OP_DIVU = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]     opb;
   logic                 op_div;
   logic                 accept;
   logic                 is_multi;
   logic                 last_iter;
   logic [WIDTH-1:0]     fast_y;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH-1:0]     rem_sub;

   assign accept    = (state == S_IDLE) && start;
   assign is_multi  = (ctrl == OP_MULU) || (ctrl == OP_DIVU);
   assign last_iter = (state == S_RUN) && (cnt == CNT_W'(1));

   // State register; reset abandons any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: DONE always returns to IDLE so a start there is dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = is_multi ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (last_iter) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decode directly from the state register.
   always_comb begin
      busy = (state == S_RUN);
      done = (state == S_DONE);
   end

   // Single-cycle result; the reserved opcode falls through to AND.
   always_comb begin
      fast_y = a & b;
      case (ctrl)
         OP_OR:   fast_y = a | b;
         OP_ADD:  fast_y = a + b;
         OP_SUB:  fast_y = a - b;
         OP_SLT:  fast_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: fast_y = a & b;
      endcase
   end

   // One shift-add or restoring-divide step on the shared accumulator.
   // With a zero divisor every trial subtract succeeds, so the quotient
   // fills with ones and the dividend shifts intact into the remainder.
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      rem_sh  = acc[2*WIDTH-1:WIDTH-1];
      rem_sub = rem_sh[WIDTH-1:0] - opb;
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      if (op_div) begin
         if (rem_sh >= {1'b0, opb}) begin
            acc_nxt = {rem_sub, acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Datapath: operand capture, iteration and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         y      <= '0;
         hi     <= '0;
         zero   <= 1'b1;
         dz     <= 1'b0;
         acc    <= '0;
         opb    <= '0;
         op_div <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         if (is_multi) begin
            acc    <= {{WIDTH{1'b0}}, a};
            opb    <= b;
            op_div <= (ctrl == OP_DIVU);
            cnt    <= CNT_W'(WIDTH);
         end else begin
            y    <= fast_y;
            hi   <= '0;
            zero <= (fast_y == '0);
            dz   <= 1'b0;
         end
      end else if (state == S_RUN) begin
         acc <= acc_nxt;
         cnt <= cnt - CNT_W'(1);
         if (last_iter) begin
            y    <= acc_nxt[WIDTH-1:0];
            hi   <= acc_nxt[2*WIDTH-1:WIDTH];
            zero <= (acc_nxt[WIDTH-1:0] == '0);
            dz   <= op_div && (opb == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit instance checked every cycle against a
// latency/arithmetic model, plus an 8-bit instance with directed checks.
module tb_alu_mc;

   localparam int W  = 32;
   localparam int W8 = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    ctrl;
   logic [W-1:0]  a, b, y, hi;
   logic          zero, busy, done, dz;

   logic          start8;
   logic [2:0]    ctrl8;
   logic [W8-1:0] a8, b8, y8, hi8;
   logic          zero8, busy8, done8, dz8;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b),
      .y(y), .hi(hi), .zero(zero), .busy(busy), .done(done), .dz(dz)
   );

   alu_mc #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .ctrl(ctrl8), .a(a8), .b(b8),
      .y(y8), .hi(hi8), .zero(zero8), .busy(busy8), .done(done8), .dz(dz8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Architectural result of one operation and its issue-to-done latency.
   function automatic void model_op(input logic [2:0] c, input logic [W-1:0] oa,
                                    input logic [W-1:0] ob, output logic [W-1:0] ry,
                                    output logic [W-1:0] rhi, output logic rdz,
                                    output int lat);
      logic [63:0] prod;
      prod = 64'd0;
      ry   = '0;
      rhi  = '0;
      rdz  = 1'b0;
      lat  = 1;
      case (c)
         3'd1: ry = oa | ob;
         3'd2: ry = oa + ob;
         3'd6: ry = oa - ob;
         3'd7: ry = ($signed(oa) < $signed(ob)) ? 32'd1 : 32'd0;
         3'd3: begin
            prod = {32'd0, oa} * {32'd0, ob};
            ry   = prod[31:0];
            rhi  = prod[63:32];
            lat  = W + 1;
         end
         3'd4: begin
            if (ob == 0) begin
               ry  = '1;
               rhi = oa;
               rdz = 1'b1;
            end else begin
               ry  = oa / ob;
               rhi = oa % ob;
            end
            lat = W + 1;
         end
         default: ry = oa & ob;
      endcase
   endfunction

   // Model: m_left counts cycles until the done cycle (0 = idle).
   int           m_left;
   int           m_lat;
   logic [W-1:0] m_y, m_hi, p_y, p_hi;
   logic         m_zero, m_dz, p_dz;

   initial begin
      m_left = 0;
      m_y = '0; m_hi = '0; m_zero = 1'b1; m_dz = 1'b0;
      p_y = '0; p_hi = '0; p_dz = 1'b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_left = 0;
            m_y = '0; m_hi = '0; m_zero = 1'b1; m_dz = 1'b0;
         end else if (m_left == 0) begin
            if (start) begin
               model_op(ctrl, a, b, p_y, p_hi, p_dz, m_lat);
               m_left = m_lat;
            end
         end else begin
            m_left--;
         end
         if (m_left == 1) begin
            m_y = p_y; m_hi = p_hi; m_zero = (p_y == 0); m_dz = p_dz;
         end
         @(negedge clk);
         if (chk_en) begin
            check("m_busy", busy, (m_left > 1));
            check("m_done", done, (m_left == 1));
            check("m_y",    y,    m_y);
            check("m_hi",   hi,   m_hi);
            check("m_zero", zero, m_zero);
            check("m_dz",   dz,   m_dz);
         end
      end
   end

   task automatic run_op(input string name, input logic [2:0] c, input logic [W-1:0] oa,
                         input logic [W-1:0] ob, input int exp_lat, input logic [W-1:0] ey,
                         input logic [W-1:0] ehi, input logic edz, input bit spam);
      int k;
      bit seen;
      @(negedge clk);
      ctrl = c; a = oa; b = ob; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      seen = 1'b0;
      while (!seen && k <= 100) begin
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (spam) begin
               start = (k % 3 == 0);
               a = $urandom;
               b = $urandom;
               ctrl = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            k++;
         end
      end
      start = 1'b0;
      check({name, "_done_seen"}, seen, 1);
      if (seen) begin
         check({name, "_latency"}, k, exp_lat);
         check({name, "_y"}, y, ey);
         check({name, "_hi"}, hi, ehi);
         check({name, "_zero"}, zero, (ey == 0));
         check({name, "_dz"}, dz, edz);
      end
   endtask

   task automatic run_op8(input string name, input logic [2:0] c, input logic [W8-1:0] oa,
                          input logic [W8-1:0] ob, input int exp_lat,
                          input logic [W8-1:0] ey, input logic [W8-1:0] ehi);
      int k;
      bit seen;
      @(negedge clk);
      ctrl8 = c; a8 = oa; b8 = ob; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      k = 1;
      seen = 1'b0;
      while (!seen && k <= 40) begin
         if (done8 === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (k < exp_lat) check({name, "_busy"}, busy8, 1);
            @(negedge clk);
            k++;
         end
      end
      check({name, "_done_seen"}, seen, 1);
      if (seen) begin
         check({name, "_latency"}, k, exp_lat);
         check({name, "_y"}, y8, ey);
         check({name, "_hi"}, hi8, ehi);
         check({name, "_busy_at_done"}, busy8, 0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ctrl = 3'd0; a = '0; b = '0;
      start8 = 1'b0; ctrl8 = 3'd0; a8 = '0; b8 = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_y", y, 0);
      check("rst_hi", hi, 0);
      check("rst_zero", zero, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst8_zero", zero8, 1);
      rst = 1'b0;

      run_op("add",  3'b010, 32'd7, 32'd5, 1, 32'd12, 32'd0, 1'b0, 1'b0);
      run_op("sub0", 3'b110, 32'd5, 32'd5, 1, 32'd0, 32'd0, 1'b0, 1'b0);
      run_op("subw", 3'b110, 32'd0, 32'd1, 1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      run_op("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 32'd0, 1'b0, 1'b0);
      run_op("slt_bnd", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 1, 32'd0, 32'd0, 1'b0, 1'b0);
      run_op("and",  3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 32'd0, 1'b0, 1'b0);
      run_op("or",   3'b001, 32'h0000_FFFF, 32'h00FF_0000, 1, 32'h00FF_FFFF, 32'd0, 1'b0, 1'b0);
      run_op("rsvd", 3'b101, 32'h0000_0F0F, 32'h0000_00FF, 1, 32'h0000_000F, 32'd0, 1'b0, 1'b0);
      run_op("mul_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1);
      run_op("mul_sh", 3'b011, 32'h1234_5678, 32'h10, 33, 32'h2345_6780, 32'h1, 1'b0, 1'b0);
      run_op("div",  3'b100, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0);
      run_op("div_small", 3'b100, 32'd5, 32'd7, 33, 32'd0, 32'd5, 1'b0, 1'b0);
      run_op("div_z", 3'b100, 32'd9, 32'd0, 33, 32'hFFFF_FFFF, 32'd9, 1'b1, 1'b1);

      // Reset during RUN cycle 10 of a multiply.
      @(negedge clk);
      ctrl = 3'b011; a = '1; b = '1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("midrun_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_busy", busy, 0);
      check("midrun_done", done, 0);
      check("midrun_y", y, 0);
      check("midrun_hi", hi, 0);
      check("midrun_zero", zero, 1);
      check("midrun_dz", dz, 0);
      run_op("add_after_rst", 3'b010, 32'd1, 32'd1, 1, 32'd2, 32'd0, 1'b0, 1'b0);

      // Simultaneous reset and start: the request is lost.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; ctrl = 3'b010; a = 32'd3; b = 32'd4;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rststart_done", done, 0);
      @(negedge clk);
      check("rststart_done2", done, 0);
      check("rststart_y", y, 0);

      // Start held high: single-cycle ops issue every second cycle.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = 1'b1; ctrl = 3'b010; a = 32'(i * 11); b = 32'd1;
      end
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);

      run_op8("m8",   3'b011, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE);
      run_op8("d8",   3'b100, 8'hFF, 8'h10, 9, 8'h0F, 8'h0F);
      run_op8("a8",   3'b010, 8'hF0, 8'h20, 1, 8'h10, 8'h00);
      run_op8("slt8", 3'b111, 8'h80, 8'h7F, 1, 8'h01, 8'h00);
      run_op8("dz8",  3'b100, 8'h5A, 8'h00, 9, 8'hFF, 8'h5A);
      check("dz8_flag", dz8, 1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
